uart_tx_param: RTL

Parametrised serial transmitter, successor to the fixed 8-bit transmitter. It accepts a parallel word with a start/busy handshake and serialises it as an asynchronous frame: start bit, DATA_BITS data bits LSB first, optional parity, then 1 or 2 stop bits. It generates its own bit timing from clk and needs no external shift-register block. It sits between the command/data source and the RS232 line driver.

---
 rtl/uart_tx_param.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional even/odd parity and 1-2 stop bits, bit timing derived from clk.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state, w_next;
    logic [CW-1:0]        r_baud, w_baud_nx;
    logic [BW-1:0]        r_bit, w_bit_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic                 r_par, w_par_nx;
    logic                 r_done, w_done_nx;
    logic                 r_tx, w_tx_nx;
    logic                 r_busy;
    logic                 w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_done  <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_par   <= w_par_nx;
            r_done  <= w_done_nx;
            r_tx    <= w_tx_nx;
            r_busy  <= (w_next != S_IDLE);
        end
    end

    assign w_tick = (r_baud == BAUD_LAST);

    always_comb begin
        w_next     = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_done_nx  = 1'b0;
        if (r_state != S_IDLE) begin
            w_baud_nx = w_tick ? '0 : r_baud + CW'(1);
        end
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next     = S_START;
                    w_shift_nx = data;
                    w_par_nx   = (PARITY_MODE == 2) ? ~(^data) : (^data);
                    w_baud_nx  = '0;
                    w_bit_nx   = '0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_next   = S_DATA;
                    w_bit_nx = '0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nx = r_shift >> 1;
                    if (r_bit == DATA_LAST) begin
                        w_bit_nx = '0;
                        w_next   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nx = r_bit + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_next   = S_STOP;
                    w_bit_nx = '0;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit == STOP_LAST) begin
                        w_next    = S_IDLE;
                        w_bit_nx  = '0;
                        w_done_nx = 1'b1;
                    end else begin
                        w_bit_nx = r_bit + BW'(1);
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Line level is registered from the next state so tx is glitch-free.
    always_comb begin
        w_tx_nx = 1'b1;
        unique case (w_next)
            S_IDLE:   w_tx_nx = 1'b1;
            S_START:  w_tx_nx = 1'b0;
            S_DATA:   w_tx_nx = w_shift_nx[0];
            S_PARITY: w_tx_nx = w_par_nx;
            S_STOP:   w_tx_nx = 1'b1;
            default:  w_tx_nx = 1'b1;
        endcase
    end

    assign busy = r_busy;
    assign done = r_done;
    assign tx   = r_tx;

endmodule
